// File: rtl/piso_pkg.sv
// Shared definitions for the piso_flex width converter.
//   clog2      : ceiling log2 used to size the slice counters
//   DEF_*      : default parallel/serial widths
//   state_e    : occupancy state, encoded as {nxt.valid, cur.valid}
//   slot_t     : slot view {data, num, last, valid} at the default widths
package piso_pkg;

  localparam int unsigned DEF_IN_W  = 64;
  localparam int unsigned DEF_OUT_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  typedef struct packed {
    logic [DEF_IN_W-1:0]                         data;
    logic [clog2(DEF_IN_W/DEF_OUT_W + 1)-1:0]    num;
    logic                                        last;
    logic                                        valid;
  } slot_t;

endpackage

// File: rtl/piso_flex_if.sv
// Handshake bundle for piso_flex.
//   IN_VLD/IN_RDY/IN_DAT/IN_NUM/IN_LAST : wide word input side
//   OUT_VLD/OUT_RDY/OUT_DAT/OUT_LAST    : narrow slice output side
//   BUSY                                : a word is buffered in the converter
// slave = converter view, master = producer/consumer (bench) view.
interface piso_flex_if
  import piso_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = DEF_IN_W,
  parameter int unsigned DATA_OUT_WIDTH = DEF_OUT_W
);
  localparam int unsigned NUM   = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int unsigned CNT_W = clog2(NUM + 1);

  logic                      IN_VLD;
  logic                      IN_LAST;
  logic [DATA_IN_WIDTH-1:0]  IN_DAT;
  logic [CNT_W-1:0]          IN_NUM;
  logic                      IN_RDY;
  logic [DATA_OUT_WIDTH-1:0] OUT_DAT;
  logic                      OUT_VLD;
  logic                      OUT_LAST;
  logic                      OUT_RDY;
  logic                      BUSY;

  modport slave (
    input  IN_VLD, IN_LAST, IN_DAT, IN_NUM, OUT_RDY,
    output IN_RDY, OUT_DAT, OUT_VLD, OUT_LAST, BUSY
  );

  modport master (
    output IN_VLD, IN_LAST, IN_DAT, IN_NUM, OUT_RDY,
    input  IN_RDY, OUT_DAT, OUT_VLD, OUT_LAST, BUSY
  );
endinterface

// File: rtl/piso_slot.sv
// One word buffer slot: captures data/num/last and raises valid on load,
// drops valid on clear. The slice count is clamped at capture so that
// 0 or anything above NUM means a full word.
//   CLK, RST_N        : clock, async active-low reset
//   load_i, clear_i   : capture (wins) / invalidate
//   data_i/num_i/last_i : word to capture
//   data_o/num_o/last_o/valid_o : stored slot contents
module piso_slot #(
  parameter int unsigned DW    = 64,
  parameter int unsigned NUM   = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [DW-1:0]    data_i,
  input  logic [CNT_W-1:0] num_i,
  input  logic             last_i,
  output logic [DW-1:0]    data_o,
  output logic [CNT_W-1:0] num_o,
  output logic             last_o,
  output logic             valid_o
);
  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM);

  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    num_d   = num_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      num_d   = ((num_i == '0) || (num_i > NUM_C)) ? NUM_C : num_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      last_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q  <= '0;
      num_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      num_q   <= num_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign num_o   = num_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/piso_flex.sv
// Parallel-in/serial-out width converter with per-word slice count,
// selectable slice order and a two-entry (cur + skid nxt) input buffer.
//   CLK, RST_N : clock, async active-low reset
//   bus        : piso_flex_if.slave -- IN_* word input with registered IN_RDY,
//                OUT_* slice output, BUSY while a word is held
// Slices are selected by index from the held word; the word is never shifted.
module piso_flex
  import piso_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = DEF_IN_W,
  parameter int unsigned DATA_OUT_WIDTH = DEF_OUT_W,
  parameter bit          MSB_FIRST      = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  piso_flex_if.slave   bus
);
  localparam int unsigned      NUM   = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int unsigned      CNT_W = clog2(NUM + 1);
  localparam logic [CNT_W-1:0] TOP_C = CNT_W'(NUM - 1);

  logic [DATA_IN_WIDTH-1:0] cur_data, nxt_data, cur_din;
  logic [CNT_W-1:0]         cur_num, nxt_num, cur_nin;
  logic                     cur_last, nxt_last, cur_lin;
  logic                     cur_valid, nxt_valid;
  logic                     cur_load, cur_clear, nxt_load, nxt_clear, cur_from_nxt;
  logic [CNT_W-1:0]         idx_q, idx_d, sel;
  logic                     in_hs, out_hs, at_end, fin;
  logic [DATA_OUT_WIDTH-1:0] slice;
  state_e                   state;

  // cur is refilled either from the skid entry or straight from the input
  assign cur_din = cur_from_nxt ? nxt_data : bus.IN_DAT;
  assign cur_nin = cur_from_nxt ? nxt_num  : bus.IN_NUM;
  assign cur_lin = cur_from_nxt ? nxt_last : bus.IN_LAST;

  piso_slot #(.DW(DATA_IN_WIDTH), .NUM(NUM), .CNT_W(CNT_W)) u_cur (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load_i  (cur_load),
    .clear_i (cur_clear),
    .data_i  (cur_din),
    .num_i   (cur_nin),
    .last_i  (cur_lin),
    .data_o  (cur_data),
    .num_o   (cur_num),
    .last_o  (cur_last),
    .valid_o (cur_valid)
  );

  piso_slot #(.DW(DATA_IN_WIDTH), .NUM(NUM), .CNT_W(CNT_W)) u_nxt (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load_i  (nxt_load),
    .clear_i (nxt_clear),
    .data_i  (bus.IN_DAT),
    .num_i   (bus.IN_NUM),
    .last_i  (bus.IN_LAST),
    .data_o  (nxt_data),
    .num_o   (nxt_num),
    .last_o  (nxt_last),
    .valid_o (nxt_valid)
  );

  // occupancy state lives in the two slot valid flags
  assign state  = state_e'({nxt_valid, cur_valid});
  assign in_hs  = bus.IN_VLD & ~nxt_valid;
  assign out_hs = cur_valid & bus.OUT_RDY;
  assign at_end = (idx_q == (cur_num - CNT_W'(1)));
  assign fin    = out_hs & at_end;

  always_comb begin
    cur_load     = 1'b0;
    cur_clear    = 1'b0;
    nxt_load     = 1'b0;
    nxt_clear    = 1'b0;
    cur_from_nxt = 1'b0;
    idx_d        = idx_q;
    unique case (state)
      ST_EMPTY: begin
        if (in_hs) begin
          cur_load = 1'b1;
          idx_d    = '0;
        end
      end
      ST_ONE: begin
        if (fin) begin
          idx_d = '0;
          // final slice leaving while a word arrives: refill cur directly
          if (in_hs) cur_load  = 1'b1;
          else       cur_clear = 1'b1;
        end else begin
          if (in_hs)  nxt_load = 1'b1;
          if (out_hs) idx_d    = idx_q + CNT_W'(1);
        end
      end
      ST_TWO: begin
        if (fin) begin
          cur_load     = 1'b1;
          cur_from_nxt = 1'b1;
          nxt_clear    = 1'b1;
          idx_d        = '0;
        end else if (out_hs) begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign sel = MSB_FIRST ? (TOP_C - idx_q) : idx_q;

  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (CNT_W'(i) == sel) slice = cur_data[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    end
  end

  assign bus.IN_RDY   = ~nxt_valid;
  assign bus.OUT_VLD  = cur_valid;
  assign bus.OUT_DAT  = slice;
  assign bus.OUT_LAST = cur_valid & cur_last & at_end;
  assign bus.BUSY     = cur_valid;

  a_cfg: assert property (@(posedge CLK)
    ((DATA_IN_WIDTH % DATA_OUT_WIDTH) == 0) && (NUM >= 2));

  a_in_stable: assert property (@(posedge CLK) disable iff (!RST_N)
    (bus.IN_VLD && !bus.IN_RDY) ##1 bus.IN_VLD |->
      $stable({bus.IN_DAT, bus.IN_NUM, bus.IN_LAST}));
endmodule

// File: tb/tb_piso_flex.sv
module tb_piso_flex;
  import piso_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  piso_flex_if #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) if0 ();
  piso_flex_if #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) if1 ();

  piso_flex #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .bus(if0.slave));
  piso_flex #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST_N(RST_N), .bus(if1.slave));

  int checks = 0;
  int errors = 0;
  logic [16:0] expq[$];
  int cyc = 0, nslices = 0, first_cyc = 0, last_cyc = 0;
  int rdy_low_run = 0, rdy_low_max = 0;
  bit in_acc;
  logic [63:0] wd[8];
  logic [2:0]  wn[8];
  logic        wl[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // one cycle on if0: score any slice handshake, note input accept, advance
  task automatic tick();
    logic [16:0] e;
    in_acc = if0.IN_VLD && if0.IN_RDY;
    if (if0.OUT_VLD && if0.OUT_RDY) begin
      if (expq.size() == 0) begin
        chk("unexpected_slice", {47'd0, if0.OUT_LAST, if0.OUT_DAT}, 64'h1_FFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("slice", {47'd0, if0.OUT_LAST, if0.OUT_DAT}, {47'd0, e});
      end
      if (nslices == 0) first_cyc = cyc;
      last_cyc = cyc;
      nslices++;
    end
    if (!if0.IN_RDY) rdy_low_run++;
    else             rdy_low_run = 0;
    if (rdy_low_run > rdy_low_max) rdy_low_max = rdy_low_run;
    step();
    cyc++;
  endtask

  task automatic set_word(input int k);
    if0.IN_DAT  = wd[k];
    if0.IN_NUM  = wn[k];
    if0.IN_LAST = wl[k];
  endtask

  // offer wd[0..nw-1] back to back with OUT_RDY high until expq drains
  task automatic run_stream(input int nw);
    int k;
    k = 0;
    nslices = 0;
    rdy_low_run = 0;
    rdy_low_max = 0;
    if0.OUT_RDY = 1'b1;
    if0.IN_VLD  = 1'b1;
    set_word(0);
    for (int i = 0; i < 200 && (k < nw || expq.size() > 0); i++) begin
      tick();
      if (in_acc) begin
        k++;
        if (k < nw) set_word(k);
        else        if0.IN_VLD = 1'b0;
      end
    end
    if0.IN_VLD = 1'b0;
    chk("stream_drained", 64'(expq.size()), 64'd0);
    chk("stream_accepted", 64'(k), 64'(nw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] t2e[4];
    logic [15:0] v;

    if0.IN_VLD = 0; if0.IN_LAST = 0; if0.IN_DAT = '0; if0.IN_NUM = '0; if0.OUT_RDY = 0;
    if1.IN_VLD = 0; if1.IN_LAST = 0; if1.IN_DAT = '0; if1.IN_NUM = '0; if1.OUT_RDY = 0;

    // reset state
    repeat (3) step();
    chk("rst_out_vld",  64'(if0.OUT_VLD),  64'd0);
    chk("rst_out_last", 64'(if0.OUT_LAST), 64'd0);
    chk("rst_out_dat",  64'(if0.OUT_DAT),  64'd0);
    chk("rst_busy",     64'(if0.BUSY),     64'd0);
    chk("rst_in_rdy",   64'(if0.IN_RDY),   64'd1);
    RST_N = 1'b1;
    step();

    // single word, LSB slice first
    nslices = 0;
    expq.push_back(17'h0_1111); expq.push_back(17'h0_2222);
    expq.push_back(17'h0_3333); expq.push_back(17'h1_4444);
    if0.IN_DAT = 64'h4444_3333_2222_1111; if0.IN_NUM = 3'd4; if0.IN_LAST = 1'b1;
    if0.IN_VLD = 1'b1; if0.OUT_RDY = 1'b1;
    tick();
    if0.IN_VLD = 1'b0;
    chk("t1_latency_vld", 64'(if0.OUT_VLD), 64'd1);
    repeat (4) tick();
    chk("t1_count", 64'(nslices), 64'd4);
    chk("t1_idle_vld", 64'(if0.OUT_VLD), 64'd0);
    chk("t1_idle_busy", 64'(if0.BUSY), 64'd0);

    // single word, MSB slice first
    t2e[0] = 17'h0_4444; t2e[1] = 17'h0_3333; t2e[2] = 17'h0_2222; t2e[3] = 17'h1_1111;
    if1.IN_DAT = 64'h4444_3333_2222_1111; if1.IN_NUM = 3'd4; if1.IN_LAST = 1'b1;
    if1.IN_VLD = 1'b1; if1.OUT_RDY = 1'b1;
    step();
    if1.IN_VLD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_vld", 64'(if1.OUT_VLD), 64'd1);
      chk("t2_slice", {47'd0, if1.OUT_LAST, if1.OUT_DAT}, {47'd0, t2e[k]});
      step();
    end
    chk("t2_idle_vld", 64'(if1.OUT_VLD), 64'd0);
    chk("t2_idle_rdy", 64'(if1.IN_RDY), 64'd1);
    chk("t2_idle_busy", 64'(if1.BUSY), 64'd0);

    // 8 back-to-back full words
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        v = 16'hB000 + 16'(4*k + j);
        wd[k][16*j +: 16] = v;
        expq.push_back({(k == 7 && j == 3), v});
      end
      wn[k] = 3'd4;
      wl[k] = (k == 7);
    end
    run_stream(8);
    chk("t3_slices", 64'(nslices), 64'd32);
    chk("t3_no_bubble", 64'(last_cyc - first_cyc + 1), 64'd32);
    chk("t3_rdy_low_le3", 64'(rdy_low_max <= 3), 64'd1);

    // partial words: 2, 0 (full) and 7 (clamped to full)
    wd[0] = 64'hAAA4_AAA3_AAA2_AAA1; wn[0] = 3'd2; wl[0] = 1'b1;
    wd[1] = 64'hBBB4_BBB3_BBB2_BBB1; wn[1] = 3'd0; wl[1] = 1'b1;
    wd[2] = 64'hCCC4_CCC3_CCC2_CCC1; wn[2] = 3'd7; wl[2] = 1'b1;
    expq.push_back(17'h0_AAA1); expq.push_back(17'h1_AAA2);
    expq.push_back(17'h0_BBB1); expq.push_back(17'h0_BBB2);
    expq.push_back(17'h0_BBB3); expq.push_back(17'h1_BBB4);
    expq.push_back(17'h0_CCC1); expq.push_back(17'h0_CCC2);
    expq.push_back(17'h0_CCC3); expq.push_back(17'h1_CCC4);
    run_stream(3);
    chk("t4_slices", 64'(nslices), 64'd10);
    chk("t4_no_bubble", 64'(last_cyc - first_cyc + 1), 64'd10);

    // backpressure mid-word with two more words offered
    begin
      int acc;
      acc = 0;
      nslices = 0;
      for (int j = 1; j <= 4; j++) expq.push_back({1'b0, 16'h8000 + 16'(j)});
      for (int j = 1; j <= 4; j++) expq.push_back({1'b0, 16'h9000 + 16'(j)});
      for (int j = 1; j <= 4; j++) expq.push_back({(j == 4), 16'hA000 + 16'(j)});
      if0.IN_DAT = 64'h8004_8003_8002_8001; if0.IN_NUM = 3'd4; if0.IN_LAST = 1'b0;
      if0.IN_VLD = 1'b1; if0.OUT_RDY = 1'b1;
      tick();
      if0.IN_VLD = 1'b0;
      tick();
      tick();
      if0.OUT_RDY = 1'b0;
      if0.IN_DAT = 64'h9004_9003_9002_9001; if0.IN_NUM = 3'd4; if0.IN_LAST = 1'b0;
      if0.IN_VLD = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (in_acc) begin
          acc++;
          if0.IN_DAT = 64'hA004_A003_A002_A001; if0.IN_NUM = 3'd4; if0.IN_LAST = 1'b1;
        end
        chk("t5_hold_rdy", 64'(if0.IN_RDY), 64'd0);
        chk("t5_hold_dat", 64'(if0.OUT_DAT), 64'h8003);
        chk("t5_hold_vld", 64'(if0.OUT_VLD), 64'd1);
      end
      chk("t5_one_extra", 64'(acc), 64'd1);
      if0.OUT_RDY = 1'b1;
      for (int i = 0; i < 40 && expq.size() > 0; i++) begin
        tick();
        if (in_acc) begin
          acc++;
          if0.IN_VLD = 1'b0;
        end
      end
      if0.IN_VLD = 1'b0;
      chk("t5_drained", 64'(expq.size()), 64'd0);
      chk("t5_slices", 64'(nslices), 64'd12);
      chk("t5_accepts", 64'(acc), 64'd2);
      chk("t5_idle_busy", 64'(if0.BUSY), 64'd0);
    end

    // reset mid-word with skid entry full
    nslices = 0;
    expq.push_back(17'h0_5001); expq.push_back(17'h0_5002);
    if0.IN_DAT = 64'h5004_5003_5002_5001; if0.IN_NUM = 3'd4; if0.IN_LAST = 1'b1;
    if0.IN_VLD = 1'b1; if0.OUT_RDY = 1'b1;
    tick();
    if0.IN_DAT = 64'h6004_6003_6002_6001;
    tick();
    if0.IN_VLD = 1'b0;
    tick();
    chk("t6_pre_dat", 64'(if0.OUT_DAT), 64'h5003);
    chk("t6_pre_rdy", 64'(if0.IN_RDY), 64'd0);
    chk("t6_pre_q", 64'(expq.size()), 64'd0);
    if0.OUT_RDY = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_vld",  64'(if0.OUT_VLD),  64'd0);
    chk("t6_rst_busy", 64'(if0.BUSY),     64'd0);
    chk("t6_rst_rdy",  64'(if0.IN_RDY),   64'd1);
    chk("t6_rst_last", 64'(if0.OUT_LAST), 64'd0);
    chk("t6_rst_dat",  64'(if0.OUT_DAT),  64'd0);
    step();
    RST_N = 1'b1;
    step();
    chk("t6_post_vld", 64'(if0.OUT_VLD), 64'd0);
    wd[0] = 64'h7004_7003_7002_7001; wn[0] = 3'd4; wl[0] = 1'b1;
    expq.push_back(17'h0_7001); expq.push_back(17'h0_7002);
    expq.push_back(17'h0_7003); expq.push_back(17'h1_7004);
    run_stream(1);
    chk("t6_slices", 64'(nslices), 64'd4);
    step();
    chk("t6_idle_vld", 64'(if0.OUT_VLD), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_flex.md
Name: piso_flex

Overview:
- Parametrised parallel-in/serial-out width converter that splits one DATA_IN_WIDTH word into up to NUM = DATA_IN_WIDTH/DATA_OUT_WIDTH output slices.
- Adds over the previous generation: a per-word valid-slice count (partial last words), selectable slice order, and a two-entry input buffer. The buffer gives bubble-free back-to-back serialisation with a registered IN_RDY (no OUT_RDY->IN_RDY combinational path).
- Sits between wide SRAM/DMA read ports and narrow PE/array input streams.

Parameters:
- DATA_IN_WIDTH, 64, parallel input width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 16, serial output slice width.
- MSB_FIRST, 0, 0 = slice 0 is IN_DAT[DATA_OUT_WIDTH-1:0] and is sent first; 1 = slice 0 is the top slice and is sent first.
- Derived, not overridable: NUM = DATA_IN_WIDTH/DATA_OUT_WIDTH (must be >= 2); CNT_W = clog2(NUM+1).

Ports:
- CLK, input, 1, clock.
- RST_N, input, 1, asynchronous active-low reset.
- IN_VLD, input, 1, input word valid.
- IN_LAST, input, 1, input word is the last word of its packet.
- IN_DAT, input, DATA_IN_WIDTH, parallel word.
- IN_NUM, input, CNT_W, number of valid slices in IN_DAT (1..NUM); 0 or >NUM means NUM.
- IN_RDY, output, 1, input accept; registered.
- OUT_DAT, output, DATA_OUT_WIDTH, current slice.
- OUT_VLD, output, 1, slice valid.
- OUT_LAST, output, 1, final slice of a word that had IN_LAST=1.
- OUT_RDY, input, 1, downstream accept.
- BUSY, output, 1, any buffered word present.

Behaviour:
- Storage:
  - cur slot (data, num, last, valid) being serialised, plus slice index idx (CNT_W bits).
  - nxt slot (data, num, last, valid) as the skid entry.
- States, encoded by {nxt.valid, cur.valid}:
  - EMPTY: cur invalid.
  - ONE: cur valid, nxt empty.
  - TWO: both valid.
- Outputs:
  - IN_RDY = !nxt.valid.
  - OUT_VLD = cur.valid.
  - OUT_DAT = slice idx of cur.data, mapped through MSB_FIRST.
  - OUT_LAST = cur.last & (idx == cur.num-1).
  - BUSY = cur.valid.
- Accept: input handshake = IN_VLD & IN_RDY. Output handshake = OUT_VLD & OUT_RDY. fin = output handshake & (idx == cur.num-1).
- Transitions (evaluated each cycle):
  - EMPTY + in: load cur, idx=0 -> ONE. OUT_VLD rises the next cycle (latency 1).
  - ONE, out handshake, not fin: idx++.
  - ONE, fin, no in: cur invalid -> EMPTY.
  - ONE, fin + in: load input directly into cur, idx=0, stay ONE. This is the zero-bubble path.
  - ONE, in, not fin: load nxt -> TWO. A non-final out handshake in the same cycle still advances idx.
  - TWO, fin: move nxt into cur, idx=0, clear nxt -> ONE. IN_RDY=0 in TWO, so no input is accepted.
  - TWO, non-final out handshake: idx++.
- Throughput: sustained 1 slice/cycle when IN_VLD and OUT_RDY are both held high.
- Output hold: OUT_DAT and OUT_LAST stay stable while OUT_VLD & !OUT_RDY.
- IN_NUM clamp: applied at capture. A clamped num=1 word occupies cur for exactly one output handshake.
- Slice data is never shifted. Selection is an index mux; unused slices are ignored.
- Reset (asynchronous, any time, including mid-word):
  - Both slots invalid, idx=0, data registers 0.
  - Outputs: OUT_VLD=0, OUT_LAST=0, OUT_DAT=0, BUSY=0, IN_RDY=1.
  - Partially sent words are dropped.
- Simulation assertions:
  - IN_DAT, IN_NUM and IN_LAST stable while IN_VLD & !IN_RDY.
  - DATA_IN_WIDTH % DATA_OUT_WIDTH == 0.

Decomposition:
- Shared package piso_pkg: clog2 function, default widths, slot struct typedef {data, num, last, valid}.
- One natural sub-module: piso_slot (a single capture register with valid/num/last and clamp logic). Instantiate it twice.
- Slice mux and control stay in piso_flex.

Test Plan:
- Single word 0x4444_3333_2222_1111, IN_NUM=4, IN_LAST=1, OUT_RDY=1, MSB_FIRST=0 -> OUT_DAT 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles starting 1 cycle after accept; OUT_LAST only on 0x4444.
- Same word with MSB_FIRST=1 -> order 0x4444,0x3333,0x2222,0x1111; OUT_LAST on 0x1111.
- 8 back-to-back words, IN_VLD=1, OUT_RDY=1 -> 32 consecutive OUT_VLD cycles with no bubble; IN_RDY never low for more than 3 consecutive cycles.
- Partial word IN_NUM=2, then IN_NUM=0, then IN_NUM=7 -> 2, 4 and 4 slices emitted respectively, with no gap between words.
- Backpressure: OUT_RDY=0 for 10 cycles mid-word while 2 more words are offered -> exactly one extra word accepted (TWO state), IN_RDY=0 afterward, OUT_DAT held; after release, all 12 slices are delivered in order.
- Reset asserted mid-word (idx=2, nxt full) -> OUT_VLD=0, BUSY=0, IN_RDY=1 immediately. The next word after release is emitted from slice 0 with no residue.
